stream_merge: RTL

N-to-1 round-robin merge stage for req/ack streams, placed directly upstream of the team's `fifo` blocks. Several producers share one FIFO write port through it. It arbitrates among requesting inputs, registers the winning word in a single-entry output buffer, and tags the word with its source index. An optional packet lock keeps the grant on one input until that input's last beat.

---
 rtl/stream_pkg.sv | 19 +
 rtl/rr_pick.sv | 37 +++
 rtl/stream_merge.sv | 109 ++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stream_pkg
//  Description : Shared constants and helpers for req/ack stream blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package stream_pkg;

    localparam int   C_DW_DEFAULT = 8;
    localparam logic C_REQ_ON     = 1'b1;
    localparam logic C_ACK_ON     = 1'b1;

    // Source-index width for n channels; never narrower than one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker, first request at or after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
)(
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [SW-1:0] index,
    output logic          any
);

    int w_k;

    always_comb begin
        win   = '0;
        index = '0;
        any   = 1'b0;
        w_k   = 0;
        for (int i = 0; i < N; i++) begin
            w_k = int'(ptr) + i;
            if (w_k >= N) w_k = w_k - N;
            if (!any && req[w_k]) begin
                win[w_k] = 1'b1;
                index    = SW'(w_k);
                any      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_merge.sv
`default_nettype none
// ============================================================================
//  Module      : stream_merge
//  Description : N-to-1 round-robin req/ack merge with one-entry output buffer.
//                Optional packet lock: define STREAM_MERGE_PKT_LOCK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_merge
    import stream_pkg::*;
#(
    parameter int dw = C_DW_DEFAULT,
    parameter int N  = 4,
    parameter int SW = src_width(N)
)(
    input  logic            clk,
    input  logic            rstn,
    input  logic [N*dw-1:0] d_in,
    input  logic [N-1:0]    last_in,
    input  logic [N-1:0]    req_in,
    output logic [N-1:0]    ack_in,
    output logic [dw-1:0]   d_out,
    output logic            last_out,
    output logic [SW-1:0]   src_out,
    output logic            req_out,
    input  logic            ack_out
);

    localparam logic [SW-1:0] C_LAST_IDX = SW'(N - 1);

    logic [N-1:0]  w_pick_req;
    logic [N-1:0]  w_win;
    logic [SW-1:0] w_idx;
    logic          w_any;
    logic          w_space;
    logic          w_in_xfer;
    logic [SW-1:0] w_ptr_adv;

    logic          r_valid;
    logic [dw-1:0] r_d;
    logic          r_last;
    logic [SW-1:0] r_src;
    logic [SW-1:0] r_ptr;

`ifdef STREAM_MERGE_PKT_LOCK_EN
    logic          r_lock;
    logic [SW-1:0] r_lock_id;

    // While a packet is open only its owner is visible to the picker.
    assign w_pick_req = r_lock ? (req_in & (N'(1) << r_lock_id)) : req_in;
`else
    assign w_pick_req = req_in;
`endif

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (w_pick_req),
        .ptr   (r_ptr),
        .win   (w_win),
        .index (w_idx),
        .any   (w_any)
    );

    // Grants are held off while reset is asserted so no producer sees a lost ack.
    assign w_space   = ~r_valid | ack_out;
    assign w_in_xfer = w_any & w_space & rstn;
    assign ack_in    = w_win & {N{w_space & rstn}};
    assign w_ptr_adv = (w_idx == C_LAST_IDX) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid   <= 1'b0;
            r_d       <= '0;
            r_last    <= 1'b0;
            r_src     <= '0;
            r_ptr     <= '0;
`ifdef STREAM_MERGE_PKT_LOCK_EN
            r_lock    <= 1'b0;
            r_lock_id <= '0;
`endif
        end else if (w_in_xfer) begin
            r_valid <= 1'b1;
            r_d     <= d_in[w_idx*dw +: dw];
            r_last  <= last_in[w_idx];
            r_src   <= w_idx;
`ifdef STREAM_MERGE_PKT_LOCK_EN
            if (last_in[w_idx]) begin
                r_lock <= 1'b0;
                r_ptr  <= w_ptr_adv;
            end else begin
                r_lock    <= 1'b1;
                r_lock_id <= w_idx;
            end
`else
            r_ptr   <= w_ptr_adv;
`endif
        end else if (ack_out) begin
            r_valid <= 1'b0;
        end
    end

    assign req_out  = r_valid;
    assign d_out    = r_d;
    assign last_out = r_last;
    assign src_out  = r_src;

endmodule
`default_nettype wire
